// File: rtl/strobe_multiplier_pkg.sv
// strobe_multiplier_pkg: shared types and constants for the PLL strobe chain.
// Generator state and divider timing helpers.
package strobe_multiplier_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gen_state_e;

    localparam int WIDTH_DEF  = 7;
    localparam int PWIDTH_DEF = 16;

    // Serial divider produces one quotient bit per cycle.
    function automatic int div_latency(input int pwidth);
        return pwidth;
    endfunction

    // Shortest period whose division finishes and is captured in time.
    function automatic int min_period(input int pwidth);
        return div_latency(pwidth) + 2;
    endfunction

endpackage

// File: rtl/strobe_multiplier_if.sv
// strobe_multiplier_if: reference strobe in, multiplied strobe out.
// Master drives strobe_in/R, slave returns strobe_out/locked.
interface strobe_multiplier_if #(
    parameter int WIDTH = 7
);

    logic             strobe_in;
    logic [WIDTH-1:0] R;
    logic             strobe_out;
    logic             locked;

    modport master (
        output strobe_in,
        output R,
        input  strobe_out,
        input  locked
    );

    modport slave (
        input  strobe_in,
        input  R,
        output strobe_out,
        output locked
    );

endinterface

// File: rtl/strobe_multiplier_serial_divider.sv
// serial_divider: restoring divider, one quotient bit per cycle.
// A start while busy abandons the running division.
module serial_divider
    import strobe_multiplier_pkg::*;
#(
    parameter int PWIDTH = PWIDTH_DEF,
    parameter int WIDTH  = WIDTH_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [PWIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic [PWIDTH-1:0] quotient,
    output logic [WIDTH-1:0]  remainder
);

    localparam int CW = $clog2(PWIDTH + 1);
    localparam logic [CW-1:0] LAT = CW'(div_latency(PWIDTH));

    logic [PWIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PWIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0]  rmd_q, rmd_d;

    logic [WIDTH:0]    trial;
    logic [WIDTH:0]    diff;
    logic              ge;

    assign trial = {rem_q, acc_q[PWIDTH-1]};
    assign diff  = trial - {1'b0, dvs_q};
    assign ge    = (trial >= {1'b0, dvs_q});

    // One restoring step per busy cycle; latch result on the last step.
    always_comb begin
        acc_d  = acc_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        quo_d  = quo_q;
        rmd_d  = rmd_q;
        if (start) begin
            acc_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            cnt_d  = LAT;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = {acc_q[PWIDTH-2:0], ge};
            rem_d = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                quo_d  = acc_d;
                rmd_d  = rem_d;
            end
        end
    end

    // Divider state registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quo_q  <= '0;
            rmd_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            quo_q  <= quo_d;
            rmd_q  <= rmd_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;

endmodule

// File: rtl/strobe_multiplier.sv
// strobe_multiplier: emits R evenly spaced strobes per strobe_in.
// Spacing comes from the previous measured period, Bresenham-spread.
module strobe_multiplier
    import strobe_multiplier_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int PWIDTH = PWIDTH_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    strobe_multiplier_if.slave sm
);

    localparam logic [PWIDTH-1:0] MIN_P = PWIDTH'(min_period(PWIDTH));

    // Period measurement and division result.
    logic [PWIDTH-1:0] pcnt_q, pcnt_d;
    logic              seen_q, seen_d;
    logic              pend_ok_q, pend_ok_d;
    logic [WIDTH-1:0]  pend_r_q, pend_r_d;
    logic [PWIDTH-1:0] res_quo_q, res_quo_d;
    logic [WIDTH-1:0]  res_rem_q, res_rem_d;
    logic [WIDTH-1:0]  res_r_q, res_r_d;
    logic              res_ok_q, res_ok_d;

    // Generator.
    gen_state_e        state_q, state_d;
    logic [PWIDTH-1:0] icnt_q, icnt_d;
    logic [WIDTH-1:0]  err_q, err_d;
    logic [WIDTH-1:0]  gcnt_q, gcnt_d;
    logic [PWIDTH-1:0] gq_q, gq_d;
    logic [WIDTH-1:0]  gm_q, gm_d;
    logic [WIDTH-1:0]  gr_q, gr_d;
    logic              strobe_q, strobe_d;
    logic              locked_q, locked_d;

    logic              strobe;
    logic              r_zero;
    logic              pcnt_sat;
    logic [PWIDTH-1:0] period;
    logic              meas_ok;

    logic              div_busy;
    logic              div_done;
    logic [PWIDTH-1:0] div_quo;
    logic [WIDTH-1:0]  div_rem;

    logic [WIDTH-1:0]  b_err;
    logic [PWIDTH-1:0] b_q;
    logic [WIDTH-1:0]  b_m;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH:0]    b_sum;
    logic [WIDTH:0]    b_diff;
    logic              b_wrap;
    logic [PWIDTH-1:0] b_ivl;
    logic [WIDTH-1:0]  b_err_nx;

    assign strobe   = sm.strobe_in;
    assign r_zero   = (sm.R == '0);
    assign pcnt_sat = &pcnt_q;
    assign period   = pcnt_q + PWIDTH'(1);
    assign meas_ok  = seen_q && !pcnt_sat && (period >= MIN_P) && !r_zero;

    serial_divider #(
        .PWIDTH (PWIDTH),
        .WIDTH  (WIDTH)
    ) u_div (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (strobe),
        .dividend  (period),
        .divisor   (sm.R),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Measure periods, tag each division, capture finished results.
    always_comb begin
        pcnt_d    = pcnt_q;
        seen_d    = seen_q;
        pend_ok_d = pend_ok_q;
        pend_r_d  = pend_r_q;
        res_quo_d = res_quo_q;
        res_rem_d = res_rem_q;
        res_r_d   = res_r_q;
        res_ok_d  = res_ok_q;
        if (strobe) begin
            pcnt_d    = '0;
            seen_d    = 1'b1;
            pend_ok_d = meas_ok;
            pend_r_d  = sm.R;
            res_ok_d  = 1'b0;
        end else begin
            if (!pcnt_sat) begin
                pcnt_d = pcnt_q + PWIDTH'(1);
            end
            if (div_done && !div_busy) begin
                res_quo_d = div_quo;
                res_rem_d = div_rem;
                res_r_d   = pend_r_q;
                res_ok_d  = pend_ok_q && (div_quo != '0);
            end
        end
    end

    // Next interval and error term, from fresh result on reload.
    always_comb begin
        b_err    = strobe ? '0 : err_q;
        b_q      = strobe ? res_quo_q : gq_q;
        b_m      = strobe ? res_rem_q : gm_q;
        b_r      = strobe ? res_r_q : gr_q;
        b_sum    = {1'b0, b_err} + {1'b0, b_m};
        b_diff   = b_sum - {1'b0, b_r};
        b_wrap   = (b_sum >= {1'b0, b_r});
        b_ivl    = b_q + PWIDTH'(b_wrap);
        b_err_nx = b_wrap ? b_diff[WIDTH-1:0] : b_sum[WIDTH-1:0];
    end

    // Generator FSM: strobe_in reloads, RUN counts out R-1 strobes.
    always_comb begin
        state_d  = state_q;
        icnt_d   = icnt_q;
        err_d    = err_q;
        gcnt_d   = gcnt_q;
        gq_d     = gq_q;
        gm_d     = gm_q;
        gr_d     = gr_q;
        strobe_d = 1'b0;
        locked_d = locked_q;
        if (strobe) begin
            strobe_d = !r_zero;
            locked_d = res_ok_q;
            gq_d     = res_quo_q;
            gm_d     = res_rem_q;
            gr_d     = res_r_q;
            gcnt_d   = '0;
            icnt_d   = b_ivl;
            err_d    = b_err_nx;
            if (res_ok_q && !r_zero && (res_r_q > WIDTH'(1))) begin
                state_d = RUN;
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                RUN: begin
                    if (icnt_q == PWIDTH'(1)) begin
                        strobe_d = 1'b1;
                        gcnt_d   = gcnt_q + WIDTH'(1);
                        icnt_d   = b_ivl;
                        err_d    = b_err_nx;
                        if (gcnt_d == gr_q - WIDTH'(1)) begin
                            state_d = IDLE;
                        end
                    end else begin
                        icnt_d = icnt_q - PWIDTH'(1);
                    end
                end
            endcase
        end
    end

    // Measurement and result registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pcnt_q    <= '0;
            seen_q    <= 1'b0;
            pend_ok_q <= 1'b0;
            pend_r_q  <= '0;
            res_quo_q <= '0;
            res_rem_q <= '0;
            res_r_q   <= '0;
            res_ok_q  <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            seen_q    <= seen_d;
            pend_ok_q <= pend_ok_d;
            pend_r_q  <= pend_r_d;
            res_quo_q <= res_quo_d;
            res_rem_q <= res_rem_d;
            res_r_q   <= res_r_d;
            res_ok_q  <= res_ok_d;
        end
    end

    // Generator registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            icnt_q   <= '0;
            err_q    <= '0;
            gcnt_q   <= '0;
            gq_q     <= '0;
            gm_q     <= '0;
            gr_q     <= '0;
            strobe_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            icnt_q   <= icnt_d;
            err_q    <= err_d;
            gcnt_q   <= gcnt_d;
            gq_q     <= gq_d;
            gm_q     <= gm_d;
            gr_q     <= gr_d;
            strobe_q <= strobe_d;
            locked_q <= locked_d;
        end
    end

    assign sm.strobe_out = strobe_q;
    assign sm.locked     = locked_q;

endmodule
